// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and the
// baud divisor calculation used by both the transmitter and the receiver.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;

  // System clocks per oversampled tick, rounded to nearest and never below 1.
  function automatic int baud_divisor(input int clk_freq,
                                      input int baud_rate,
                                      input int oversampling);
    int den;
    int div;
    den = baud_rate * oversampling;
    div = (clk_freq + den / 2) / den;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversampled baud tick generator: one-cycle tick every
// baud_divisor() system clocks.
`timescale 1ns/1ps
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLING = 16
) (
  input  logic i_clk,
  input  logic i_aresetn,
  output logic o_tick
);

  localparam int DIV = baud_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLING);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = o_tick ? '0 : cnt_q + CW'(1);
  end

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on valid/ready in IDLE and shifts it
// out LSB-first from a registered serial output, OVERSAMPLING ticks per bit.
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLING = 16
) (
  input  logic                 i_clk,
  input  logic                 i_aresetn,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_serial,
  output logic                 o_tx_done
);

  localparam int TW = $clog2(OVERSAMPLING);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;

  logic baud_tick;
  logic bit_end;

  baud_tick_gen #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .OVERSAMPLING (OVERSAMPLING)
  ) u_baud_tick_gen (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .o_tick    (baud_tick)
  );

  assign bit_end = baud_tick && (tick_cnt_q == TICK_LAST);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    // The tick counter only runs inside a frame; it wraps to 0 on bit_end.
    if (state_q != IDLE && baud_tick) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_tx_valid) begin
          shift_d    = i_tx_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so the flop changes on the
    // same edge as the state, including the accepting edge.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      serial_q   <= serial_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_ready  = (state_q == IDLE);
  assign o_tx_serial = serial_q;
  assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at one tick per clock (16-cycle bits), with a
// behavioural mid-bit sampling receiver for the loopback run.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CLK_FREQ     = 1600000;
  localparam int BAUD_RATE    = 100000;
  localparam int OVERSAMPLING = 16;

  logic       clk = 1'b0;
  logic       aresetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_done;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .OVERSAMPLING (OVERSAMPLING)
  ) dut (
    .i_clk       (clk),
    .i_aresetn   (aresetn),
    .i_tx_data   (tx_data),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (tx_ready),
    .o_tx_serial (tx_serial),
    .o_tx_done   (tx_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural receiver: detect falling edge, sample mid-bit every 16 cycles.
  logic       rx_en   = 1'b0;
  logic       rx_prev = 1'b1;
  logic [7:0] rx_q[$];

  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rx_en && rx_prev && !tx_serial) begin
        repeat (8) @(negedge clk);
        check("rx_start", 16'(tx_serial), 16'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          d[i] = tx_serial;
        end
        repeat (16) @(negedge clk);
        check("rx_stop", 16'(tx_serial), 16'h1);
        rx_q.push_back(d);
      end
      rx_prev = tx_serial;
    end
  end

  // Called at the negedge where valid && ready is sampled (n = 0). Cycle n is
  // the n-th negedge after that: start bit n=1..16, data bit k at
  // n=17+16k..32+16k, stop bit n=145..160, done and ready high at n=161.
  task automatic frame(input string tag, input logic [7:0] b, input bit hold,
                       input logic [7:0] nxt, input bit mess);
    logic exp_s;
    for (int n = 1; n <= 161; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check($sformatf("%s_ready_low", tag), 16'(tx_ready), 16'h0);
        if (hold) tx_data = nxt;
        else      tx_valid = 1'b0;
      end
      if (mess && n > 1 && n < 150) begin
        tx_data  = 8'($urandom);
        tx_valid = n[0];
      end
      if (mess && n == 150) tx_valid = 1'b0;
      if (n <= 16)       exp_s = 1'b0;
      else if (n <= 144) exp_s = b[(n - 17) / 16];
      else               exp_s = 1'b1;
      if (n % 16 == 1 || n % 16 == 0)
        check($sformatf("%s_line_n%0d", tag, n), 16'(tx_serial), 16'(exp_s));
      if (n == 80)  check($sformatf("%s_ready_mid", tag), 16'(tx_ready), 16'h0);
      if (n == 160) check($sformatf("%s_done_early", tag), 16'(tx_done), 16'h0);
      if (n == 161) begin
        check($sformatf("%s_done", tag), 16'(tx_done), 16'h1);
        check($sformatf("%s_ready_back", tag), 16'(tx_ready), 16'h1);
        check($sformatf("%s_line_idle", tag), 16'(tx_serial), 16'h1);
      end
    end
  endtask

  task automatic start_byte(input string tag, input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    check($sformatf("%s_handshake", tag), 16'(tx_ready), 16'h1);
  endtask

  task automatic after_frame(input string tag);
    @(negedge clk);
    check($sformatf("%s_after", tag), 16'({tx_done, tx_serial, tx_ready}), 16'b011);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("send_timeout", 16'(t), 16'h0);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int t;

    aresetn  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", 16'({tx_serial, tx_ready, tx_done}), 16'b110);
    aresetn = 1'b1;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), 16'({tx_serial, tx_ready, tx_done}), 16'b110);
    end

    start_byte("a5", 8'hA5);
    frame("a5", 8'hA5, 1'b0, 8'h00, 1'b0);
    after_frame("a5");

    // Valid held high: 0xFF is taken in the done cycle of the 0x00 frame.
    start_byte("b2b0", 8'h00);
    frame("b2b0", 8'h00, 1'b1, 8'hFF, 1'b0);
    frame("b2b1", 8'hFF, 1'b0, 8'h00, 1'b0);
    after_frame("b2b1");

    start_byte("noise", 8'h3C);
    frame("noise", 8'h3C, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("noise_quiet_%0d", i), 16'({tx_done, tx_serial, tx_ready}), 16'b011);
    end

    // 0x55: bit 3 (low) spans n=65..80; reset lands at n=70.
    start_byte("rst55", 8'h55);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (69) @(negedge clk);
    check("rst55_bit3", 16'(tx_serial), 16'h0);
    aresetn = 1'b0;
    #1;
    check("rst55_async", 16'({tx_serial, tx_ready, tx_done}), 16'b110);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    start_byte("post_rst", 8'h81);
    frame("post_rst", 8'h81, 1'b0, 8'h00, 1'b0);
    after_frame("post_rst");

    rx_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b);
    end
    t = 0;
    while (rx_q.size() < 256 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rx_count", 16'(rx_q.size()), 16'd256);
    for (int i = 0; i < 256 && i < rx_q.size(); i++)
      check($sformatf("rx_byte_%0d", i), 16'(rx_q[i]), 16'(exp_q[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that accepts one byte per valid/ready handshake and shifts it out LSB-first as a standard 8N1 frame: one start bit, 8 data bits, one stop bit. It is the transmit companion to the existing UART receiver and shares its baud/oversampling parameters. Bit timing is derived from the same oversampled baud tick: each bit lasts exactly OVERSAMPLING ticks. It sits between the core-side byte source (FIFO or register interface) and the TX pad.

## Interface
- CLK_FREQ, 100000000: system clock frequency, Hz.
- BAUD_RATE, 115200: line bit rate, baud.
- OVERSAMPLING, 16: baud ticks per bit; power of two, ≥ 4.
- i_clk  input  1  system clock; all logic on rising edge.
- i_aresetn  input  1  reset, asynchronous assert, active-low.
- i_tx_data  input  8  byte to send; sampled only at handshake.
- i_tx_valid  input  1  source has a byte.
- o_tx_ready  output  1  block can accept a byte (IDLE only).
- o_tx_serial  output  1  serial line; idle/mark = 1.
- o_tx_done  output  1  one-cycle pulse when stop bit completes.
- The design has one clock, i_clk. Reset is i_aresetn, which is asynchronous and active-low.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: o_tx_serial=1, o_tx_ready=1. When i_tx_valid && o_tx_ready:
  - latch i_tx_data into an 8-bit shift register;
  - clear the tick counter (clog2(OVERSAMPLING) bits) and the bit counter (3 bits);
  - go to START.
- START: o_tx_serial=0. On the baud tick where tick_cnt==OVERSAMPLING-1: clear tick_cnt and go to DATA.
- DATA: o_tx_serial = shift_reg[0]. On the bit-end tick:
  - shift right;
  - increment bit_cnt;
  - after bit_cnt==7 completes, go to STOP.
- STOP: o_tx_serial=1. On the bit-end tick: go to IDLE and assert o_tx_done for exactly one cycle (the first IDLE cycle).
- Tick counter increments only on baud_tick. It wraps from OVERSAMPLING-1 to 0, and the wrap marks the bit end.
- i_tx_valid outside IDLE is ignored; i_tx_data changes after acceptance have no effect.
- o_tx_serial is driven from a flop: no combinational path from inputs and no glitches.

## Timing
- Reset values: state=IDLE, o_tx_serial=1, o_tx_ready=1, o_tx_done=0, counters=0, shift_reg=0.
- Handshake-to-start latency: o_tx_serial falls on the clock edge that accepts the byte, so it is low in the cycle after acceptance.
- Each bit spans OVERSAMPLING baud ticks. The first bit's length is measured from the first tick after acceptance; the tick generator free-runs and is not realigned.
- o_tx_ready drops in the cycle after acceptance. It returns to 1 in the same cycle as o_tx_done.
- Back-to-back frames: a byte offered while o_tx_done=1 is accepted that cycle. The next start bit then follows the stop bit with no extra idle bit.
- Reset mid-frame: outputs return to reset values immediately (asynchronously). The line goes to 1 and the partial frame is abandoned.
- Simultaneous accept and tick in IDLE: the tick is not counted toward the start bit.

## Structure
- Shared package uart_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP};
  - constant DATA_BITS = 8;
  - the function computing the tick divisor from CLK_FREQ, BAUD_RATE and OVERSAMPLING. This same function is used by the receiver's tick generator.
- One sub-module: baud_tick_gen, the existing oversampled tick generator, instantiated with identical parameters.
- The FSM, counters and shift register are in the top module.

## Test plan
Bench parameters: CLK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLING=16. This gives one tick per clock, so one bit = 16 cycles and one frame = 160 cycles.
- Reset, then hold i_tx_valid=0 for 200 cycles → o_tx_serial=1, o_tx_ready=1, o_tx_done=0 throughout.
- Send 0xA5 → line shows 0, then 1,0,1,0,0,1,0,1, then 1, each 16 cycles. o_tx_done pulses once at cycle 160 after acceptance.
- Send 0x00, then 0xFF back-to-back with valid held high → the second byte is accepted in the o_tx_done cycle. Total time is 320 cycles, with no idle gap between the stop bit and the next start bit.
- Toggle i_tx_data and i_tx_valid during an active frame carrying 0x3C → the transmitted bits still encode 0x3C and there is no extra acceptance.
- Assert i_aresetn=0 during the 4th data bit of 0x55 → o_tx_serial=1 and o_tx_ready=1 immediately. After release, the block sends 0x81 correctly.
- Receiver loopback: connect o_tx_serial to the receiver and send 256 random bytes → all bytes are received in order and match.
